vga_frame_reader: RTL and testbench

Read-side consumer of the camera frame buffer. Generates 640x480@60 VGA timing from a single 25 MHz pixel clock, drives the buffer's read address with the scaled image coordinate, and converts the returned 8-bit RGB332 pixel to 12-bit RGB444 for the VGA DAC pins. Sync and blanking are delay-matched to the buffer's one-cycle registered read, so colour and sync leave the block aligned.

---
 rtl/vga_frame_reader.sv | 144 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA reader for the camera frame buffer: scales stored image
// coordinates into buffer addresses and converts RGB332 pixels to RGB444.
module vga_frame_reader #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned H_ACT = 640,
  parameter int unsigned H_FP  = 16,
  parameter int unsigned H_SYN = 96,
  parameter int unsigned H_BP  = 48,
  parameter int unsigned V_ACT = 480,
  parameter int unsigned V_FP  = 10,
  parameter int unsigned V_SYN = 2,
  parameter int unsigned V_BP  = 33
) (
  input  logic          clk_r,
  input  logic          rst_n,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic          frame_start
);

  localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYN + H_BP;
  localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYN + V_BP;
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned HS_BEG = H_ACT + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYN;
  localparam int unsigned VS_BEG = V_ACT + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYN;

  // Low SHIFT bits of v all-ones marks the last screen line of a stored row.
  localparam logic [VW-1:0] V_MASK = VW'((1 << SHIFT) - 1);

  localparam int unsigned F_HS  = 0;
  localparam int unsigned F_VS  = 1;
  localparam int unsigned F_DE  = 2;
  localparam int unsigned F_IMG = 3;
  localparam int unsigned F_FS  = 4;
  localparam logic [4:0]  FL_RST = 5'b00011;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [4:0]    fl_c, fl1_q, fl2_q;
  logic [3:0]    r_q, g_q, b_q, r_d, g_d, b_d;
  logic          hs_q, vs_q, de_q, fs_q;
  logic          active_c, in_img_c;

  // Raster counters and row base; frame wrap takes priority over row advance.
  always_comb begin
    h_d   = h_q + 1'b1;
    v_d   = v_q;
    row_d = row_q;
    if (h_q == HW'(H_TOT - 1)) begin
      h_d = '0;
      if (v_q == VW'(V_TOT - 1)) begin
        v_d   = '0;
        row_d = '0;
      end else begin
        v_d = v_q + 1'b1;
        if (((v_q & V_MASK) == V_MASK) && ((v_q >> SHIFT) < VW'(IMG_H - 1))) begin
          row_d = row_q + AW'(IMG_W);
        end
      end
    end
  end

  // Stage-0 decode of timing flags and image window.
  always_comb begin
    active_c    = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
    in_img_c    = active_c && ((h_q >> SHIFT) < HW'(IMG_W)) && ((v_q >> SHIFT) < VW'(IMG_H));
    fl_c        = '0;
    fl_c[F_HS]  = !((h_q >= HW'(HS_BEG)) && (h_q < HW'(HS_END)));
    fl_c[F_VS]  = !((v_q >= VW'(VS_BEG)) && (v_q < VW'(VS_END)));
    fl_c[F_DE]  = active_c;
    fl_c[F_IMG] = in_img_c;
    fl_c[F_FS]  = (h_q == '0) && (v_q == '0);
    addr_d      = in_img_c ? (row_q + AW'(h_q >> SHIFT)) : '0;
  end

  // RGB332 -> RGB444 by replicating MSBs; blanked outside the image window.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (fl2_q[F_IMG]) begin
      r_d = {data_in[7:5], data_in[7]};
      g_d = {data_in[4:2], data_in[4]};
      b_d = {data_in[1:0], data_in[1:0]};
    end
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      row_q  <= '0;
      addr_q <= '0;
      fl1_q  <= FL_RST;
      fl2_q  <= FL_RST;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      fl1_q  <= fl_c;
      fl2_q  <= fl1_q;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= fl2_q[F_HS];
      vs_q   <= fl2_q[F_VS];
      de_q   <= fl2_q[F_DE];
      fs_q   <= fl2_q[F_FS];
    end
  end

  assign addr_out    = addr_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: one full-size instance plus two reduced-timing
// instances (SHIFT=2 fill and SHIFT=0 window) so whole frames stay short.
module tb_vga_frame_reader;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  // d0: default 640x480 timing, data = addr[7:0]
  logic [14:0] a0;
  logic [7:0]  ram0_q;
  logic [3:0]  r0, g0, b0;
  logic        hs0, vs0, de0, fs0;
  // s1: 16x12 active (24x17 total), 4x3 image, SHIFT=2, data = addr[7:0]
  logic [14:0] a1;
  logic [7:0]  ram1_q;
  logic [3:0]  r1, g1, b1;
  logic        hs1, vs1, de1, fs1;
  // s0: same timing, SHIFT=0 window, data = ~addr[7:0] so blank reads are nonzero
  logic [14:0] a2;
  logic [7:0]  ram2_q;
  logic [3:0]  r2, g2, b2;
  logic        hs2, vs2, de2, fs2;

  vga_frame_reader u_d0 (
    .clk_r(clk), .rst_n(rst_n), .addr_out(a0), .data_in(ram0_q),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0),
    .vga_de(de0), .frame_start(fs0)
  );

  vga_frame_reader #(
    .IMG_W(4), .IMG_H(3), .SHIFT(2),
    .H_ACT(16), .H_FP(2), .H_SYN(3), .H_BP(3),
    .V_ACT(12), .V_FP(1), .V_SYN(2), .V_BP(2)
  ) u_s1 (
    .clk_r(clk), .rst_n(rst_n), .addr_out(a1), .data_in(ram1_q),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_de(de1), .frame_start(fs1)
  );

  vga_frame_reader #(
    .IMG_W(4), .IMG_H(3), .SHIFT(0),
    .H_ACT(16), .H_FP(2), .H_SYN(3), .H_BP(3),
    .V_ACT(12), .V_FP(1), .V_SYN(2), .V_BP(2)
  ) u_s0 (
    .clk_r(clk), .rst_n(rst_n), .addr_out(a2), .data_in(ram2_q),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2),
    .vga_de(de2), .frame_start(fs2)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    ram0_q <= a0[7:0];
    ram1_q <= a1[7:0];
    ram2_q <= ~a2[7:0];
  end

  // Clocks since reset release; at the falling edge with cyc=k the counters sit at position k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    if (cyc > n) begin
      errors++;
      $display("FAIL wait_cyc: already at %0d, wanted %0d", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    wait_cyc(500);
    checks++;
    if (de0 !== 1'b1) begin errors++; $display("FAIL pre_reset_de: got %b want 1", de0); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hs0, vs0, de0, fs0} !== 4'b1100) begin
      errors++; $display("FAIL reset_sync: hs/vs/de/fs got %b want 1100", {hs0, vs0, de0, fs0});
    end
    checks++;
    if ({r0, g0, b0} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {r0, g0, b0}); end
    checks++;
    if (a0 !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", a0); end
    repeat (10) @(negedge clk);
    checks++;
    if ({hs0, vs0, de0, a0} !== {3'b110, 15'd0}) begin
      errors++; $display("FAIL reset_hold: hs/vs/de/addr got %b want 110/0", {hs0, vs0, de0, a0});
    end
    rst_n = 1'b1;
    wait_cyc(2);
    checks++;
    if (fs0 !== 1'b0) begin errors++; $display("FAIL fs_early: got %b want 0", fs0); end
    wait_cyc(3);
    checks++;
    if ({fs0, de0, fs1} !== 3'b111) begin
      errors++; $display("FAIL fs_first: fs0/de0/fs1 got %b want 111", {fs0, de0, fs1});
    end
    wait_cyc(4);
    checks++;
    if (fs0 !== 1'b0) begin errors++; $display("FAIL fs_width: got %b want 0", fs0); end
  endtask

  task automatic test_sync();
    int hl;
    int dh;
    hl = 0;
    dh = 0;
    apply_reset();
    wait_cyc(314);
    checks++;
    if (vs1 !== 1'b1) begin errors++; $display("FAIL vs_before: got %b want 1", vs1); end
    wait_cyc(315);
    checks++;
    if (vs1 !== 1'b0) begin errors++; $display("FAIL vs_start: got %b want 0", vs1); end
    wait_cyc(362);
    checks++;
    if (vs1 !== 1'b0) begin errors++; $display("FAIL vs_last: got %b want 0", vs1); end
    wait_cyc(363);
    checks++;
    if (vs1 !== 1'b1) begin errors++; $display("FAIL vs_end: got %b want 1", vs1); end
    wait_cyc(658);
    checks++;
    if (hs0 !== 1'b1) begin errors++; $display("FAIL hs_before: got %b want 1", hs0); end
    wait_cyc(659);
    checks++;
    if ({hs0, de0} !== 2'b00) begin errors++; $display("FAIL hs_start: hs/de got %b want 00", {hs0, de0}); end
    wait_cyc(723);
    checks++;
    if (vs1 !== 1'b0) begin errors++; $display("FAIL vs_period: got %b want 0", vs1); end
    wait_cyc(754);
    checks++;
    if (hs0 !== 1'b0) begin errors++; $display("FAIL hs_last: got %b want 0", hs0); end
    wait_cyc(755);
    checks++;
    if (hs0 !== 1'b1) begin errors++; $display("FAIL hs_end: got %b want 1", hs0); end
    wait_cyc(803);
    for (int i = 0; i < 800; i++) begin
      if (hs0 === 1'b0) hl++;
      if (de0 === 1'b1) dh++;
      @(negedge clk);
    end
    checks++;
    if (hl != 96) begin errors++; $display("FAIL hs_width: got %0d want 96", hl); end
    checks++;
    if (dh != 640) begin errors++; $display("FAIL de_per_line: got %0d want 640", dh); end
  endtask

  task automatic test_addressing();
    apply_reset();
    wait_cyc(5);
    checks++;
    if (a0 !== 15'd1) begin errors++; $display("FAIL addr_h4v0: got %0d want 1", a0); end
    wait_cyc(280);
    checks++;
    if (a1 !== 15'd11) begin errors++; $display("FAIL addr_small_last: got %0d want 11", a1); end
    wait_cyc(640);
    checks++;
    if (a0 !== 15'd159) begin errors++; $display("FAIL addr_h639v0: got %0d want 159", a0); end
    wait_cyc(641);
    checks++;
    if (a0 !== 15'd0) begin errors++; $display("FAIL addr_blank: got %0d want 0", a0); end
    wait_cyc(2404);
    checks++;
    if (a0 !== 15'd0) begin errors++; $display("FAIL addr_h3v3: got %0d want 0", a0); end
    wait_cyc(3201);
    checks++;
    if (a0 !== 15'd160) begin errors++; $display("FAIL addr_h0v4: got %0d want 160", a0); end
  endtask

  task automatic test_colour();
    apply_reset();
    wait_cyc(11);
    checks++;
    if ({de0, r0, g0, b0} !== {1'b1, 12'h00A}) begin
      errors++; $display("FAIL rgb_px8: de/rgb got %b/%h want 1/00a", de0, {r0, g0, b0});
    end
    wait_cyc(703);
    checks++;
    if ({de0, r0, g0, b0} !== {1'b0, 12'h000}) begin
      errors++; $display("FAIL rgb_hblank: de/rgb got %b/%h want 0/000", de0, {r0, g0, b0});
    end
    wait_cyc(3459);
    checks++;
    if ({r0, g0, b0} !== 12'hF00) begin errors++; $display("FAIL rgb_e0: got %h want f00", {r0, g0, b0}); end
    wait_cyc(3583);
    checks++;
    if ({r0, g0, b0} !== 12'hFFF) begin errors++; $display("FAIL rgb_ff: got %h want fff", {r0, g0, b0}); end
  endtask

  task automatic test_window();
    apply_reset();
    wait_cyc(19);
    checks++;
    if ({de2, r2, g2, b2} !== {1'b0, 12'h000}) begin
      errors++; $display("FAIL win_hblank: de/rgb got %b/%h want 0/000", de2, {r2, g2, b2});
    end
    wait_cyc(37);
    checks++;
    if ({de2, r2, g2, b2} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL win_right: de/rgb got %b/%h want 1/000", de2, {r2, g2, b2});
    end
    wait_cyc(52);
    checks++;
    if (a2 !== 15'd11) begin errors++; $display("FAIL win_addr_last: got %0d want 11", a2); end
    wait_cyc(54);
    checks++;
    if ({de2, r2, g2, b2} !== {1'b1, 12'hFB0}) begin
      errors++; $display("FAIL win_rgb_last: de/rgb got %b/%h want 1/fb0", de2, {r2, g2, b2});
    end
    wait_cyc(197);
    checks++;
    if ({de2, r2, g2, b2} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL win_below: de/rgb got %b/%h want 1/000", de2, {r2, g2, b2});
    end
  endtask

  task automatic test_frame_wrap();
    int fs_at[3];
    int nfs;
    int dcnt;
    int amax;
    nfs  = 0;
    dcnt = 0;
    amax = 0;
    for (int i = 0; i < 3; i++) fs_at[i] = -1;
    apply_reset();
    wait_cyc(1);
    while (cyc < 900) begin
      if (fs1 === 1'b1) begin
        if (nfs < 3) fs_at[nfs] = cyc;
        nfs++;
      end
      if (cyc >= 3 && cyc < 411 && de1 === 1'b1) dcnt++;
      if (cyc < 408 && int'(a1) > amax) amax = int'(a1);
      if (cyc == 409) begin
        checks++;
        if (a1 !== 15'd0) begin errors++; $display("FAIL wrap_addr0: got %0d want 0", a1); end
      end
      if (cyc == 413) begin
        checks++;
        if (a1 !== 15'd1) begin errors++; $display("FAIL wrap_addr1: got %0d want 1", a1); end
      end
      @(negedge clk);
    end
    checks++;
    if (nfs != 3) begin errors++; $display("FAIL fs_count: got %0d want 3", nfs); end
    checks++;
    if (fs_at[0] != 3) begin errors++; $display("FAIL fs_at0: got %0d want 3", fs_at[0]); end
    checks++;
    if (fs_at[1] - fs_at[0] != 408 || fs_at[2] - fs_at[1] != 408) begin
      errors++; $display("FAIL fs_period: got %0d,%0d want 408,408", fs_at[1] - fs_at[0], fs_at[2] - fs_at[1]);
    end
    checks++;
    if (dcnt != 192) begin errors++; $display("FAIL de_per_frame: got %0d want 192", dcnt); end
    checks++;
    if (amax != 11) begin errors++; $display("FAIL addr_max: got %0d want 11", amax); end
  endtask

  initial begin
    rst_n  = 1'b0;
    checks = 0;
    errors = 0;
    test_reset();
    test_sync();
    test_addressing();
    test_colour();
    test_window();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
